// File: rtl/press_count_pkg.sv
// Shared types and width helpers for the press-count scheduler slice.
package press_count_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH_RREF,
        WAIT_RREF,
        LAUNCH_ENUM,
        COLLECT,
        REPORT
    } press_sched_state_t;

    // A machine can never need more presses than it has variables (COLS-1).
    function automatic int press_weight_w(input int cols);
        return $clog2(cols);
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle used for the enumerator's solution stream.
interface axi_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/popcount.sv
// Combinational population count of an N-bit vector into a W-bit result.
module popcount #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(vec[i]);
        end
    end

endmodule

// File: rtl/press_count_scheduler.sv
// Per-machine sequencer: job -> RREF -> enumeration -> min-weight result -> running total.
// Optional PRESS_COUNT_STATS_EN adds sol_count and a sticky protocol_err output.
module press_count_scheduler
    import press_count_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int COLS    = 14,
    parameter int TOTAL_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             job_valid,
    output logic                             job_ready,
    input  logic [COLS-1:0]                  job_matrix [ROWS],
    input  logic                             job_last,
    output logic                             rref_start,
    output logic [COLS-1:0]                  rref_matrix [ROWS],
    input  logic                             rref_done,
    input  logic                             rref_inconsistent,
    output logic                             enum_start,
    axi_stream_if.slave                      solution_stream,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [press_weight_w(COLS)-1:0]  result_weight,
    output logic                             result_none,
    output logic                             total_valid,
    output logic [TOTAL_W-1:0]               total
`ifdef PRESS_COUNT_STATS_EN
    ,
    output logic [COLS-1:0]                  sol_count,
    output logic                             protocol_err
`endif
);

    localparam int VARS     = COLS - 1;
    localparam int WEIGHT_W = press_weight_w(COLS);

    press_sched_state_t state, state_nxt;

    logic                stream_ready;
    logic                last_job;
    logic [VARS-1:0]     beat_vec;
    logic [WEIGHT_W-1:0] beat_w;
    logic [WEIGHT_W-1:0] min_w;
    logic [WEIGHT_W-1:0] min_nxt;
    logic                job_fire;
    logic                done_fire;
    logic                beat_fire;
    logic                result_fire;

    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                   input logic [WEIGHT_W-1:0] b);
        logic [TOTAL_W:0] s;
        s = {1'b0, a} + {{(TOTAL_W + 1 - WEIGHT_W){1'b0}}, b};
        return s[TOTAL_W] ? '1 : s[TOTAL_W-1:0];
    endfunction

    // Solution bits beyond the bus width read as zero; bus bits above VARS are dropped.
    assign beat_vec = VARS'(solution_stream.tdata);

    popcount #(
        .N (VARS),
        .W (WEIGHT_W)
    ) u_popcount (
        .vec   (beat_vec),
        .count (beat_w)
    );

    assign solution_stream.tready = stream_ready;

    assign job_fire    = job_valid & job_ready;
    assign done_fire   = rref_done & (state == WAIT_RREF);
    assign beat_fire   = solution_stream.tvalid & stream_ready;
    assign result_fire = result_valid & result_ready;
    assign min_nxt     = (beat_w < min_w) ? beat_w : min_w;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:        if (job_fire) state_nxt = LAUNCH_RREF;
            LAUNCH_RREF: state_nxt = WAIT_RREF;
            WAIT_RREF:   if (rref_done) state_nxt = rref_inconsistent ? REPORT : LAUNCH_ENUM;
            LAUNCH_ENUM: state_nxt = COLLECT;
            COLLECT:     if (beat_fire && solution_stream.tlast) state_nxt = REPORT;
            REPORT:      if (result_fire) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Handshake and pulse outputs are registered from the next state so they read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            job_ready    <= 1'b0;
            rref_start   <= 1'b0;
            enum_start   <= 1'b0;
            stream_ready <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            job_ready    <= (state_nxt == IDLE);
            rref_start   <= (state_nxt == LAUNCH_RREF);
            enum_start   <= (state_nxt == LAUNCH_ENUM);
            stream_ready <= (state_nxt == COLLECT);
            result_valid <= (state_nxt == REPORT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rref_matrix   <= '{default: '0};
            last_job      <= 1'b0;
            min_w         <= '1;
            result_weight <= '0;
            result_none   <= 1'b0;
            total         <= '0;
            total_valid   <= 1'b0;
        end else begin
            if (job_fire) begin
                rref_matrix <= job_matrix;
                last_job    <= job_last;
                if (total_valid) begin
                    total       <= '0;
                    total_valid <= 1'b0;
                end
            end
            if (done_fire && rref_inconsistent) begin
                result_none   <= 1'b1;
                result_weight <= '0;
            end
            if (state == LAUNCH_ENUM) begin
                min_w       <= '1;
                result_none <= 1'b0;
            end
            // The closing beat's own weight is folded in before the result is captured.
            if (beat_fire) begin
                min_w <= min_nxt;
                if (solution_stream.tlast) result_weight <= min_nxt;
            end
            if (result_fire) begin
                if (!result_none) total <= sat_add(total, result_weight);
                if (last_job) total_valid <= 1'b1;
            end
        end
    end

`ifdef PRESS_COUNT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sol_count    <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == LAUNCH_ENUM) begin
                sol_count <= '0;
            end else if (beat_fire && (sol_count != '1)) begin
                sol_count <= sol_count + 1'b1;
            end
            if (rref_done && (state != WAIT_RREF)) protocol_err <= 1'b1;
        end
    end
`else
    // Without stats, a stray rref_done is simply dropped and beats are not counted.
`endif

endmodule
